// File: rtl/servo_btn_ctrl_10khz.sv
// Two-button direction command stage for the 10 kHz servo PWM: synchronise, debounce,
// timed hold and simultaneous-press freeze. Define SERVO_AUTO_SWEEP_EN for the auto sweep.
module servo_btn_ctrl_10khz #(
  parameter int unsigned DEBOUNCE_TICKS    = 200,
  parameter int unsigned HOLD_TICKS        = 10000,
  parameter int unsigned SWEEP_DWELL_TICKS = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       sweep_en,
  output logic       l_ctrl,
  output logic       r_ctrl,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    CENTER = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10,
    FREEZE = 2'b11
  } state_t;

  localparam logic [16:0] DEB_LIMIT = 17'(DEBOUNCE_TICKS);
  localparam logic [15:0] HOLD_LOAD = (HOLD_TICKS == 0) ? 16'd0 : 16'(HOLD_TICKS - 1);
  localparam logic        HOLD_EN   = (HOLD_TICKS != 0);

  // index 0 is the left button, index 1 the right button
  logic [1:0]  sync_a;
  logic [1:0]  sync_b;
  logic [1:0]  deb;
  logic [1:0]  deb_q;
  logic [15:0] deb_cnt [2];
  logic [1:0]  press;

  state_t      state_q;
  state_t      state_n;
  logic [15:0] hold_cnt;
  logic [15:0] hold_n;
  logic        hold_run;
  logic        hold_run_n;

`ifdef SERVO_AUTO_SWEEP_EN
  localparam logic [15:0] DWELL_LOAD =
    (SWEEP_DWELL_TICKS == 0) ? 16'd0 : 16'(SWEEP_DWELL_TICKS - 1);

  logic        sweep_q;
  logic        sweep_act;
  logic        sweep_act_n;
  logic [1:0]  step_q;
  logic [1:0]  step_n;
  logic [15:0] dwell_cnt;
  logic [15:0] dwell_n;

  function automatic state_t sweep_state(input logic [1:0] s);
    case (s)
      2'd0:    sweep_state = LEFT;
      2'd2:    sweep_state = RIGHT;
      default: sweep_state = CENTER;
    endcase
  endfunction
`else
  logic sweep_unused;
  assign sweep_unused = sweep_en | (SWEEP_DWELL_TICKS == 0);
`endif

  // A debounced level flips only after DEBOUNCE_TICKS consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a  <= '0;
      sync_b  <= '0;
      deb     <= '0;
      deb_q   <= '0;
      deb_cnt <= '{default: '0};
    end else begin
      sync_a <= {btn_r, btn_l};
      sync_b <= sync_a;
      deb_q  <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (({1'b0, deb_cnt[i]} + 17'd1) >= DEB_LIMIT) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] != 16'hFFFF) begin
          deb_cnt[i] <= deb_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CENTER;
      l_ctrl    <= 1'b0;
      r_ctrl    <= 1'b0;
      hold_cnt  <= '0;
      hold_run  <= 1'b0;
`ifdef SERVO_AUTO_SWEEP_EN
      sweep_q   <= 1'b0;
      sweep_act <= 1'b0;
      step_q    <= '0;
      dwell_cnt <= '0;
`endif
    end else begin
      state_q   <= state_n;
      l_ctrl    <= (state_n == LEFT) || (state_n == FREEZE);
      r_ctrl    <= (state_n == RIGHT) || (state_n == FREEZE);
      hold_cnt  <= hold_n;
      hold_run  <= hold_run_n;
`ifdef SERVO_AUTO_SWEEP_EN
      sweep_q   <= sweep_en;
      sweep_act <= sweep_act_n;
      step_q    <= step_n;
      dwell_cnt <= dwell_n;
`endif
    end
  end

  // Presses override everything, including a running sweep.
  always_comb begin
    state_n    = state_q;
    hold_n     = hold_cnt;
    hold_run_n = hold_run;
`ifdef SERVO_AUTO_SWEEP_EN
    sweep_act_n = sweep_act;
    step_n      = step_q;
    dwell_n     = dwell_cnt;
`endif
    if (press != 2'b00) begin
      case (press)
        2'b01:   state_n = LEFT;
        2'b10:   state_n = RIGHT;
        default: state_n = FREEZE;
      endcase
      hold_n     = HOLD_LOAD;
      hold_run_n = HOLD_EN;
`ifdef SERVO_AUTO_SWEEP_EN
      sweep_act_n = 1'b0;
`endif
    end else begin
`ifdef SERVO_AUTO_SWEEP_EN
      if (sweep_act) begin
        if (!sweep_en) begin
          state_n     = CENTER;
          sweep_act_n = 1'b0;
        end else if (dwell_cnt == 16'd0) begin
          step_n  = step_q + 2'd1;
          dwell_n = DWELL_LOAD;
          state_n = sweep_state(step_q + 2'd1);
        end else begin
          dwell_n = dwell_cnt - 16'd1;
        end
      end else if (sweep_en && !sweep_q && (state_q == CENTER)) begin
        sweep_act_n = 1'b1;
        step_n      = 2'd0;
        dwell_n     = DWELL_LOAD;
        state_n     = LEFT;
        hold_run_n  = 1'b0;
      end else
`endif
      if (hold_run) begin
        if (hold_cnt == 16'd0) begin
          state_n    = CENTER;
          hold_run_n = 1'b0;
        end else begin
          hold_n = hold_cnt - 16'd1;
        end
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_servo_btn_ctrl_10khz.sv
// Bench for servo_btn_ctrl_10khz: two instances (hold 10 and hold 0) against a
// sample-window / time-since-press reference model, directed plus random stimulus.
module tb_servo_btn_ctrl_10khz;

  localparam int DEB   = 4;
  localparam int HOLD  = 10;
  localparam int DWELL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_l;
  logic       btn_r;
  logic       sweep_en;
  logic       l_ctrl;
  logic       r_ctrl;
  logic [1:0] state;
  logic       l_ctrl0;
  logic       r_ctrl0;
  logic [1:0] state0;

  int checks = 0;
  int errors = 0;

  // model: index 0 = hold-10 instance, index 1 = hold-0 instance
  logic [1:0]     m_state [2];
  logic [1:0]     m_dir   [2];
  int             m_last  [2];
  bit             m_sw    [2];
  int             m_sw_start [2];
  logic [1:0]     rawh [2];
  logic [DEB-1:0] hist [2];
  bit             deb  [2];
  bit             pend [2];
  bit             sen_prev;
  int             n;

  servo_btn_ctrl_10khz #(
    .DEBOUNCE_TICKS(DEB), .HOLD_TICKS(HOLD), .SWEEP_DWELL_TICKS(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .sweep_en(sweep_en),
    .l_ctrl(l_ctrl), .r_ctrl(r_ctrl), .state(state)
  );

  servo_btn_ctrl_10khz #(
    .DEBOUNCE_TICKS(DEB), .HOLD_TICKS(0), .SWEEP_DWELL_TICKS(DWELL)
  ) dut_h0 (
    .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .sweep_en(sweep_en),
    .l_ctrl(l_ctrl0), .r_ctrl(r_ctrl0), .state(state0)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] decode(input logic [1:0] s);
    case (s)
      2'b00:   decode = 4'b0000;
      2'b01:   decode = 4'b1001;
      2'b10:   decode = 4'b0110;
      default: decode = 4'b1111;
    endcase
  endfunction

  function automatic logic [7:0] expected();
    expected = {decode(m_state[0]), decode(m_state[1])};
  endfunction

  function automatic logic [7:0] observed();
    observed = {l_ctrl, r_ctrl, state, l_ctrl0, r_ctrl0, state0};
  endfunction

  function automatic logic [1:0] sweep_pos(input int k);
    case ((k / DWELL) % 4)
      0:       sweep_pos = 2'b01;
      2:       sweep_pos = 2'b10;
      default: sweep_pos = 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 2'b00;
      m_dir[i]   = 2'b00;
      m_last[i]  = -1000000;
      m_sw[i]    = 0;
      m_sw_start[i] = 0;
      rawh[i]    = 2'b00;
      hist[i]    = '0;
      deb[i]     = 0;
      pend[i]    = 0;
    end
    sen_prev = 0;
  endtask

  task automatic model_edge();
    logic [1:0] nxt;
    bit pl;
    bit pr;
    pl = pend[0];
    pr = pend[1];
    n++;
    for (int i = 0; i < 2; i++) begin
      int hold;
      hold = (i == 0) ? HOLD : 0;
      if (pl || pr) begin
        nxt = (pl && pr) ? 2'b11 : (pl ? 2'b01 : 2'b10);
        m_dir[i]  = nxt;
        m_last[i] = n;
        m_sw[i]   = 0;
      end
`ifdef SERVO_AUTO_SWEEP_EN
      else if (m_sw[i]) begin
        if (!sweep_en) begin
          m_sw[i]  = 0;
          m_dir[i] = 2'b00;
          nxt      = 2'b00;
        end else begin
          nxt = sweep_pos(n - m_sw_start[i]);
        end
      end else if (sweep_en && !sen_prev && m_state[i] == 2'b00) begin
        m_sw[i]       = 1;
        m_sw_start[i] = n;
        m_dir[i]      = 2'b00;
        nxt           = 2'b01;
      end
`endif
      else begin
        nxt = (hold == 0 || (n - m_last[i]) < hold) ? m_dir[i] : 2'b00;
      end
      m_state[i] = nxt;
    end
    for (int b = 0; b < 2; b++) begin
      bit raw;
      bit syn;
      raw = (b == 0) ? btn_l : btn_r;
      syn = rawh[b][1];
      rawh[b] = {rawh[b][0], raw};
      hist[b] = {hist[b][DEB-2:0], syn};
      pend[b] = 0;
      if (hist[b] == {DEB{~deb[b]}}) begin
        deb[b]  = ~deb[b];
        pend[b] = deb[b];
      end
    end
    sen_prev = sweep_en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_l = 1'b0; btn_r = 1'b0; sweep_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_async got=%b exp=%b", observed(), 8'h00);
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (observed() !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc=%0d got=%b exp=%b", i, observed(), 8'h00);
      end
    end
  endtask

  task automatic test_press_left();
    btn_l = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL left_model cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
      if (i == 6 || i == 7 || i == 16 || i == 17) begin
        logic [3:0] want;
        want = (i == 6 || i == 17) ? 4'b0000 : 4'b1001;
        checks++;
        if ({l_ctrl, r_ctrl, state} !== want) begin
          errors++;
          $display("[TB] FAIL left_timing cyc=%0d got=%b exp=%b", i, {l_ctrl, r_ctrl, state}, want);
        end
      end
    end
    btn_l = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL left_release cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
    end
    checks++;
    if (state0 !== 2'b01) begin
      errors++;
      $display("[TB] FAIL hold0_persist got=%b exp=%b", state0, 2'b01);
    end
  endtask

  task automatic test_glitch();
    logic [12:0] pattern;
    pattern = 13'b1110001010000;
    for (int i = 0; i < 25; i++) begin
      btn_r = (i < 13) ? pattern[12-i] : 1'b0;
      step();
      checks++;
      if (observed() !== 8'b0000_1001 || observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL glitch cyc=%0d got=%b exp=%b", i, observed(), 8'b0000_1001);
      end
    end
  endtask

  task automatic test_override();
    btn_l = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 5) btn_r = 1'b1;
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL override_model cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
      if (i == 11 || i == 12 || i == 21 || i == 22) begin
        logic [3:0] want;
        want = (i == 11) ? 4'b1001 : (i == 22) ? 4'b0000 : 4'b0110;
        checks++;
        if ({l_ctrl, r_ctrl, state} !== want) begin
          errors++;
          $display("[TB] FAIL override_timing cyc=%0d got=%b exp=%b", i, {l_ctrl, r_ctrl, state}, want);
        end
      end
    end
    btn_l = 1'b0; btn_r = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL override_idle cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
    end
  endtask

  task automatic test_simultaneous();
    btn_l = 1'b1; btn_r = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      step();
      if (i == 30) begin btn_l = 1'b0; btn_r = 1'b0; end
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL freeze_model cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
      if (i == 7 || i == 16 || i == 17 || i == 45) begin
        logic [7:0] want;
        want = (i == 17 || i == 45) ? 8'b0000_1111 : 8'b1111_1111;
        checks++;
        if (observed() !== want) begin
          errors++;
          $display("[TB] FAIL freeze_timing cyc=%0d got=%b exp=%b", i, observed(), want);
        end
      end
    end
    btn_l = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 10) btn_l = 1'b0;
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL unfreeze_model cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
      if (i == 6 || i == 7) begin
        logic [1:0] want;
        want = (i == 6) ? 2'b11 : 2'b01;
        checks++;
        if (state0 !== want) begin
          errors++;
          $display("[TB] FAIL unfreeze_hold0 cyc=%0d got=%b exp=%b", i, state0, want);
        end
      end
    end
  endtask

  task automatic test_sweep();
    rst = 1'b1; sweep_en = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
    model_reset();
    #1;
    @(negedge clk) rst = 1'b0;
    repeat (3) step();
    sweep_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [1:0] want;
      step();
`ifdef SERVO_AUTO_SWEEP_EN
      want = sweep_pos(i - 1);
`else
      want = 2'b00;
`endif
      checks++;
      if (state !== want || observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL sweep_seq cyc=%0d got=%b exp=%b", i, state, want);
      end
    end
    btn_l = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (j == 8) btn_l = 1'b0;
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL sweep_press_model cyc=%0d got=%b exp=%b", j, observed(), expected());
      end
      if (j == 7 || j == 16 || j == 17 || j == 20) begin
        logic [1:0] want;
        want = (j <= 16) ? 2'b01 : 2'b00;
        checks++;
        if (state !== want) begin
          errors++;
          $display("[TB] FAIL sweep_press cyc=%0d got=%b exp=%b", j, state, want);
        end
      end
    end
    sweep_en = 1'b0;
    repeat (2) step();
    sweep_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL sweep_restart cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
    end
    sweep_en = 1'b0;
    step();
    checks++;
    if (state !== 2'b00 || observed() !== expected()) begin
      errors++;
      $display("[TB] FAIL sweep_fall got=%b exp=%b", state, 2'b00);
    end
    sweep_en = 1'b1;
    repeat (4) step();
    rst = 1'b1; sweep_en = 1'b0;
    model_reset();
    #1;
    checks++;
    if (observed() !== 8'h00) begin
      errors++;
      $display("[TB] FAIL sweep_reset got=%b exp=%b", observed(), 8'h00);
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL post_reset cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
    end
  endtask

  task automatic test_random();
    int len_l = 0;
    int len_r = 0;
    int len_s = 0;
    for (int i = 0; i < 800; i++) begin
      if (len_l == 0) begin btn_l = 1'($urandom_range(0, 1)); len_l = $urandom_range(1, 9); end
      if (len_r == 0) begin btn_r = 1'($urandom_range(0, 1)); len_r = $urandom_range(1, 9); end
      if (len_s == 0) begin sweep_en = 1'($urandom_range(0, 1)); len_s = $urandom_range(5, 60); end
      len_l--; len_r--; len_s--;
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL random cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
    end
  endtask

  initial begin
    n = 0;
    test_reset();
    test_press_left();
    test_glitch();
    test_override();
    test_simultaneous();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
